tybec_leaf_map_pipe: RTL and testbench

//  Parametrised leaf map node for TyBEC-generated kernels: NLANES-wide vector binary integer op
//  (add/sub/mul/max) on two joined input streams, fixed-latency datapath pipeline.

---
 rtl/tybec_leaf_map_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_tybec_leaf_map_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tybec_leaf_map_pipe.sv
// ============================================================================
// tybec_leaf_map_pipe
// ----------------------------------------------------------------------------
// Leaf map node for TyBEC-generated kernels. It applies a per-lane binary
// integer op (add / sub / mul / signed max) to two joined NLANES-wide input
// streams. The datapath is a fixed-latency pipeline that never stalls. A
// credit counter, together with a first-word fall-through result buffer,
// absorbs downstream back-pressure.
//
// Neither iready nor ovalid has a combinational path from oready. Both are
// derived from registered state and rst only.
//
// Parameters
//   STREAMW     bits per lane element
//   NLANES      vector lanes; lane i occupies [i*STREAMW +: STREAMW]
//   LATENCY     accept-to-ovalid latency in cycles (>= 1)
//   OPCODE      0 add, 1 sub (in1-in2), 2 mul (low STREAMW bits), 3 signed max
//   OBUF_DEPTH  result buffer entries (>= LATENCY+1 for 1 item/cycle)
//
// Ports
//   clk           in   clock, all logic on posedge
//   rst           in   synchronous, active-high reset
//   ivalid_in1    in   operand 1 stream valid
//   ivalid_in2    in   operand 2 stream valid
//   in1, in2      in   operand vectors (NLANES*STREAMW)
//   iready        out  a joined input is accepted this cycle if both valids are high
//   ovalid        out  out1 holds a valid result
//   out1          out  result vector (buffer head), all-zero when ovalid=0
//   oready        in   downstream accepts out1
//
// Optional build macro TYBEC_LEAF_PERF_EN adds two ports:
//   perf_items    out  saturating count of results popped
//   perf_stall    out  saturating count of cycles with ivalid & ~iready
// ============================================================================
module tybec_leaf_map_pipe #(
    parameter int STREAMW    = 34,
    parameter int NLANES     = 2,
    parameter int LATENCY    = 8,
    parameter int OPCODE     = 0,
    parameter int OBUF_DEPTH = LATENCY + 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ivalid_in1,
    input  logic                        ivalid_in2,
    input  logic [NLANES*STREAMW-1:0]   in1,
    input  logic [NLANES*STREAMW-1:0]   in2,
    output logic                        iready,
    output logic                        ovalid,
    output logic [NLANES*STREAMW-1:0]   out1,
    input  logic                        oready
`ifdef TYBEC_LEAF_PERF_EN
    ,
    output logic [31:0]                 perf_items,
    output logic [31:0]                 perf_stall
`endif
);

    localparam int BUSW = NLANES * STREAMW;
    localparam int CNTW = $clog2(OBUF_DEPTH + 1);
    localparam int PTRW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

    // ------------------------------------------------------------------
    // Handshake and credits
    // ------------------------------------------------------------------
    logic            ivalid;
    logic            accept;
    logic            pop;
    logic [CNTW-1:0] cnt;      // items in pipeline + items in buffer

    assign ivalid = ivalid_in1 & ivalid_in2;
    assign iready = ~rst & (cnt < CNTW'(OBUF_DEPTH));
    assign accept = ivalid & iready;
    assign pop    = ovalid & oready;

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !accept) begin
            cnt <= cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane arithmetic (wraps modulo 2^STREAMW)
    // ------------------------------------------------------------------
    function automatic logic [STREAMW-1:0] lane_op(input logic [STREAMW-1:0] a,
                                                   input logic [STREAMW-1:0] b);
        case (OPCODE)
            0:       lane_op = a + b;
            1:       lane_op = a - b;
            2:       lane_op = a * b;   // STREAMW-wide context keeps the low bits
            3:       lane_op = ($signed(a) > $signed(b)) ? a : b;
            default: lane_op = '0;
        endcase
    endfunction

    logic [BUSW-1:0] op_result;

    // NOTE: the default assignment first keeps this block free of inferred
    // latches even if a lane were skipped.
    always_comb begin
        op_result = '0;
        for (int l = 0; l < NLANES; l++) begin
            op_result[l*STREAMW +: STREAMW] = lane_op(in1[l*STREAMW +: STREAMW],
                                                      in2[l*STREAMW +: STREAMW]);
        end
    end

    // ------------------------------------------------------------------
    // Datapath pipeline. The buffer write is the final stage, so there are
    // LATENCY-1 pipeline registers ahead of it. Credits guarantee a free
    // buffer slot, so the pipeline shifts every cycle.
    // ------------------------------------------------------------------
    logic            wr_en;
    logic [BUSW-1:0] wr_data;

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign wr_en   = accept;
            assign wr_data = op_result;
        end else begin : g_pipe
            logic [LATENCY-2:0] pipe_valid;
            logic [BUSW-1:0]    pipe_data [LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= accept;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        pipe_valid[s] <= pipe_valid[s-1];
                    end
                end
            end

            // NOTE: data registers carry no reset; only the valid bits decide
            // whether a stage is meaningful, so resetting data buys nothing.
            always_ff @(posedge clk) begin
                pipe_data[0] <= op_result;
                for (int s = 1; s < LATENCY - 1; s++) begin
                    pipe_data[s] <= pipe_data[s-1];
                end
            end

            assign wr_en   = pipe_valid[LATENCY-2];
            assign wr_data = pipe_data[LATENCY-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result buffer: first-word fall-through FIFO
    // ------------------------------------------------------------------
    logic [BUSW-1:0] mem [OBUF_DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] buf_cnt;

    function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
        next_ptr = (p == PTRW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (wr_en && !pop) begin
                buf_cnt <= buf_cnt + 1'b1;
            end else if (pop && !wr_en) begin
                buf_cnt <= buf_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // rst gates ovalid directly, so a mid-stream reset hides the head at once.
    assign ovalid = ~rst & (buf_cnt != '0);
    assign out1   = ovalid ? mem[rd_ptr] : '0;

`ifdef TYBEC_LEAF_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_items <= '0;
            perf_stall <= '0;
        end else begin
            if (pop && perf_items != 32'hFFFF_FFFF) begin
                perf_items <= perf_items + 32'd1;
            end
            if (ivalid && !iready && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tybec_leaf_map_pipe.sv
// ============================================================================
// tb_tybec_leaf_map_pipe
// ----------------------------------------------------------------------------
// Self-checking bench. The main DUT (defaults: 34-bit lanes, 2 lanes,
// LATENCY 8, add) is compared every cycle against a transaction-level model:
// a queue of accepted items, each tagged with the cycle in which it becomes
// visible. A bank of four 8-bit instances, one per opcode, checks the
// arithmetic against hand-computed vectors.
// ============================================================================
module tb_tybec_leaf_map_pipe;

    localparam int W     = 34;
    localparam int NL    = 2;
    localparam int LAT   = 8;
    localparam int DEPTH = LAT + 2;
    localparam int BW    = W * NL;
    localparam int BLAT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          v1, v2, oready;
    logic [BW-1:0] a, b, out1;
    logic          iready, ovalid;

    int errors = 0;
    int checks = 0;

`ifdef TYBEC_LEAF_PERF_EN
    logic [31:0] perf_items, perf_stall;
    logic [31:0] bank_pi [4];
    logic [31:0] bank_ps [4];
`endif

    tybec_leaf_map_pipe #(
        .STREAMW(W), .NLANES(NL), .LATENCY(LAT), .OPCODE(0), .OBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .ivalid_in1(v1), .ivalid_in2(v2),
        .in1(a), .in2(b),
        .iready(iready), .ovalid(ovalid), .out1(out1), .oready(oready)
`ifdef TYBEC_LEAF_PERF_EN
        , .perf_items(perf_items), .perf_stall(perf_stall)
`endif
    );

    // 8-bit bank, one instance per opcode, shared stimulus
    logic        bv;
    logic [15:0] ba, bb;
    logic [15:0] bout [4];
    logic        bov  [4];
    logic        bir  [4];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_bank
            tybec_leaf_map_pipe #(
                .STREAMW(8), .NLANES(2), .LATENCY(BLAT), .OPCODE(g)
            ) u_bank (
                .clk(clk), .rst(rst),
                .ivalid_in1(bv), .ivalid_in2(bv),
                .in1(ba), .in2(bb),
                .iready(bir[g]), .ovalid(bov[g]), .out1(bout[g]), .oready(1'b1)
`ifdef TYBEC_LEAF_PERF_EN
                , .perf_items(bank_pi[g]), .perf_stall(bank_ps[g])
`endif
            );
        end
    endgenerate

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model and per-cycle compare
    // ------------------------------------------------------------------
    typedef struct {
        logic [BW-1:0] data;
        int            arrive;
    } item_t;

    item_t q[$];
    int    cyc       = 0;
    int    pops      = 0;
    int    first_pop = -1;
    int    last_pop  = -1;
    int    accepts   = 0;

    function automatic logic [BW-1:0] model_add(input logic [BW-1:0] x, input logic [BW-1:0] y);
        logic [BW-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) begin
            r[l*W +: W] = x[l*W +: W] + y[l*W +: W];
        end
        return r;
    endfunction

    always @(negedge clk) begin : compare
        logic          exp_ir, exp_ov;
        logic [BW-1:0] exp_out;
        exp_ir  = !rst && (q.size() < DEPTH);
        exp_ov  = !rst && (q.size() > 0) && (q[0].arrive <= cyc);
        exp_out = exp_ov ? q[0].data : '0;
        check("iready", iready, exp_ir);
        check("ovalid", ovalid, exp_ov);
        check("out1", out1, exp_out);

        if (ovalid && oready) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (v1 && v2 && iready) accepts++;

        if (rst) begin
            q.delete();
        end else begin
            if (exp_ov && oready) void'(q.pop_front());
            if (v1 && v2 && exp_ir) q.push_back('{data: model_add(a, b), arrive: cyc + LAT});
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns k = number of negedges (1..20) until ovalid, 0 if it never rose.
    task automatic wait_out(output int k, output logic [BW-1:0] d);
        k = 0;
        d = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ovalid) begin
                k = i;
                d = out1;
                break;
            end
        end
    endtask

    task automatic bank_send(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic [63:0] exps);
        int k;
        ba = x;
        bb = y;
        bv = 1'b1;
        @(negedge clk);
        check({tag, " bank iready"}, {bir[3], bir[2], bir[1], bir[0]}, 4'hF);
        tick();
        bv = 1'b0;
        k  = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bov[0]) begin
                k = i;
                break;
            end
        end
        check({tag, " bank latency"}, k, BLAT);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("%s op%0d", tag, g), bout[g], exps[g*16 +: 16]);
        end
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : stim
        int            k, stalls, j;
        logic [BW-1:0] d;

        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; a = '0; b = '0; oready = 1'b1;
        bv = 1'b0; ba = '0; bb = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Test 1: single item, lanes {lane1, lane0} = {5,-3} + {2,4}
        a  = {34'd5, 34'h3_FFFF_FFFD};
        b  = {34'd2, 34'd4};
        v1 = 1'b1; v2 = 1'b1;
        @(negedge clk);
        check("t1 iready after rst", iready, 1'b1);
        tick();
        v1 = 1'b0; v2 = 1'b0;
        wait_out(k, d);
        check("t1 latency", k, LAT);
        check("t1 out1", d, {34'd7, 34'd1});
        @(negedge clk);
        check("t1 ovalid drops", ovalid, 1'b0);
        tick();

        // Test 2: 100 back-to-back items with wrapping operands
        pops = 0; first_pop = -1; last_pop = -1; stalls = 0;
        for (int i = 0; i < 100; i++) begin
            a  = {34'(i * 3 + 1), 34'h3_FFFF_FFF0 + 34'(i)};
            b  = {34'(i), 34'(i * 7)};
            v1 = 1'b1; v2 = 1'b1;
            @(negedge clk);
            if (!iready) stalls++;
            tick();
        end
        v1 = 1'b0; v2 = 1'b0;
        repeat (LAT + 4) tick();
        check("t2 stalls", stalls, 0);
        check("t2 pops", pops, 100);
        check("t2 pop span", last_pop - first_pop, 99);

        // Test 3: downstream blocked, source holds data until accepted
        oready = 1'b0; accepts = 0; j = 0;
        for (int c = 0; c < 20; c++) begin
            a  = {34'(j + 1000), 34'(j * 11)};
            b  = {34'(j), 34'h2_0000_0000};
            v1 = 1'b1; v2 = 1'b1;
            @(negedge clk);
            if (iready) j++;
            tick();
        end
        check("t3 accepts", accepts, DEPTH);
        @(negedge clk);
        check("t3 iready full", iready, 1'b0);
        tick();
        v1 = 1'b0; v2 = 1'b0; oready = 1'b1; pops = 0;
        repeat (LAT + DEPTH + 4) tick();
        check("t3 drained", pops, DEPTH);

        // Test 4: in1 valid four cycles before in2
        pops = 0; accepts = 0;
        a  = {34'h3_FFFF_FFFF, 34'd100};
        b  = {34'd1, 34'h2_0000_0000};
        v1 = 1'b1; v2 = 1'b0;
        repeat (4) tick();
        check("t4 no accept while skewed", accepts, 0);
        v2 = 1'b1;
        tick();
        v1 = 1'b0; v2 = 1'b0;
        wait_out(k, d);
        check("t4 latency", k, LAT);
        check("t4 out1", d, {34'd0, 34'h2_0000_0064});
        tick();
        repeat (3) tick();
        check("t4 single result", pops, 1);

        // Test 6: reset with 5 items in flight (some buffered, some in pipe)
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a  = {34'(i + 50), 34'(i + 60)};
            b  = {34'(i), 34'(i)};
            v1 = 1'b1; v2 = 1'b1;
            tick();
        end
        v1 = 1'b0; v2 = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6 ovalid in rst", ovalid, 1'b0);
        check("t6 out1 in rst", out1, '0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6 iready after rst", iready, 1'b1);
        check("t6 ovalid after rst", ovalid, 1'b0);
`ifdef TYBEC_LEAF_PERF_EN
        check("t6 perf_items", perf_items, 32'd0);
        check("t6 perf_stall", perf_stall, 32'd0);
`endif
        tick();
        oready = 1'b1; pops = 0;
        repeat (20) tick();
        check("t6 no stale result", pops, 0);

        // Test 5: 8-bit arithmetic; expected packed {op3, op2, op1, op0}
        bank_send("v1", {8'hFF, 8'h7F}, {8'h02, 8'h01},
                  {16'h027F, 16'hFE7F, 16'hFD7E, 16'h0180});
        bank_send("v2", {8'h80, 8'h10}, {8'h7F, 8'h10},
                  {16'h7F10, 16'h8000, 16'h0100, 16'hFF20});
        bank_send("v3", {8'h00, 8'hFF}, {8'h01, 8'h01},
                  {16'h0101, 16'h00FF, 16'hFFFE, 16'h0100});

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
